// File: rtl/nums_loader.sv
// nums_loader: synchronises and debounces the operand-entry buttons, packs eight
// 4-bit switch values into a 32-bit word and runs the start/clear handshake.

module nums_loader_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          db_q;
  logic          db_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (level_i == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      // DB_CYCLES consecutive differing samples seen: accept the new level.
      cnt_q <= '0;
      db_q  <= level_i;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_prev_q <= 1'b0;
      pulse_o   <= 1'b0;
    end else begin
      db_prev_q <= db_q;
      pulse_o   <= db_q & ~db_prev_q;
    end
  end

endmodule

module nums_loader #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  sw_i,
  input  logic        enter_i,
  input  logic        clear_i,
  input  logic        valid_i,
  output logic [31:0] nums_o,
  output logic        start_clear_o,
  output logic [3:0]  count_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    COLLECT,
    RUN,
    DONE,
    RELEASE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] nums_d;
  logic [3:0]  count_d;
  logic        start_clear_d;
  logic        done_d;

  logic [3:0]  sw_meta_q, sw_sync_q;
  logic [1:0]  btn_meta_q, btn_sync_q;
  logic        enter_p, clear_p;

  // Two-flop synchronisers; bit 0 is enter, bit 1 is clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= {clear_i, enter_i};
      btn_sync_q <= btn_meta_q;
    end
  end

  nums_loader_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_enter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .level_i (btn_sync_q[0]),
    .pulse_o (enter_p)
  );

  nums_loader_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_clear (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .level_i (btn_sync_q[1]),
    .pulse_o (clear_p)
  );

  // NOTE: the operand word is reset even though it is a data register, because
  // the sorting core must see zeros in every slot not yet entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= COLLECT;
      nums_o        <= '0;
      count_o       <= '0;
      start_clear_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nums_o        <= nums_d;
      count_o       <= count_d;
      start_clear_o <= start_clear_d;
      done_o        <= done_d;
    end
  end

  // NOTE: every output of this block is given a hold value first, so no path
  // through the case statement leaves a signal unassigned and no latch appears.
  always_comb begin
    state_d       = state_q;
    nums_d        = nums_o;
    count_d       = count_o;
    start_clear_d = start_clear_o;
    done_d        = done_o;

    case (state_q)
      COLLECT: begin
        if (clear_p) begin
          nums_d  = '0;
          count_d = '0;
        end else if (enter_p && (count_o < 4'd8)) begin
          nums_d[{count_o[2:0], 2'b00} +: 4] = sw_sync_q;
          count_d = count_o + 4'd1;
          if (count_o == 4'd7) begin
            state_d       = RUN;
            start_clear_d = 1'b1;
          end
        end
      end
      RUN: begin
        // The core cannot be aborted: button pulses are ignored here.
        if (valid_i) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (clear_p) begin
          state_d       = RELEASE;
          start_clear_d = 1'b0;
          done_d        = 1'b0;
        end
      end
      RELEASE: begin
        // Hold the core in clear until it drops its valid flag.
        if (!valid_i) begin
          state_d = COLLECT;
          nums_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_o <= 4'd8);

  a_done_implies_start: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_o |-> start_clear_o);

endmodule

// File: tb/tb_nums_loader.sv
// Self-checking bench for nums_loader: a cycle-level behavioural model built from
// input histories is compared with the DUT on every falling clock edge.

module tb_nums_loader;

  localparam int DB = 4;
  localparam int HL = DB + 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  sw_i;
  logic        enter_i;
  logic        clear_i;
  logic        valid_i;
  logic [31:0] nums_o;
  logic        start_clear_o;
  logic [3:0]  count_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  nums_loader #(
    .DB_CYCLES (DB)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sw_i          (sw_i),
    .enter_i       (enter_i),
    .clear_i       (clear_i),
    .valid_i       (valid_i),
    .nums_o        (nums_o),
    .start_clear_o (start_clear_o),
    .count_o       (count_o),
    .done_o        (done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples, newest at bit 0; the synchronised view at an edge is the raw
  // sample from two edges earlier (bit 2 after the shift).
  logic [HL-1:0] en_h, cl_h;
  logic [3:0]    sw_h [3];
  logic          m_en_db, m_cl_db;
  logic          m_en_r1, m_en_r2, m_cl_r1, m_cl_r2;
  int            m_state;  // 0 collect, 1 run, 2 done, 3 release
  logic [31:0]   m_nums;
  int            m_count;
  logic          m_sc, m_done;

  task automatic m_reset();
    en_h = '0; cl_h = '0;
    for (int i = 0; i < 3; i++) sw_h[i] = '0;
    m_en_db = 0; m_cl_db = 0;
    m_en_r1 = 0; m_en_r2 = 0; m_cl_r1 = 0; m_cl_r2 = 0;
    m_state = 0; m_nums = '0; m_count = 0; m_sc = 0; m_done = 0;
  endtask

  task automatic m_step();
    logic act_en, act_cl, rose_en, rose_cl;
    en_h = {en_h[HL-2:0], enter_i};
    cl_h = {cl_h[HL-2:0], clear_i};
    sw_h[2] = sw_h[1]; sw_h[1] = sw_h[0]; sw_h[0] = sw_i;
    // An action happens two edges after the debounced level rises.
    act_en = m_en_r2;
    act_cl = m_cl_r2;
    case (m_state)
      0: if (act_cl) begin
           m_nums = '0; m_count = 0;
         end else if (act_en) begin
           m_nums[m_count*4 +: 4] = sw_h[2];
           m_count++;
           if (m_count == 8) begin m_state = 1; m_sc = 1; end
         end
      1: if (valid_i) begin m_state = 2; m_done = 1; end
      2: if (act_cl) begin m_state = 3; m_sc = 0; m_done = 0; end
      default: if (!valid_i) begin m_state = 0; m_nums = '0; m_count = 0; end
    endcase
    // Debounced level flips once the last DB synchronised samples all disagree.
    rose_en = 0; rose_cl = 0;
    if (en_h[HL-1:2] == {DB{~m_en_db}}) begin m_en_db = ~m_en_db; rose_en = m_en_db; end
    if (cl_h[HL-1:2] == {DB{~m_cl_db}}) begin m_cl_db = ~m_cl_db; rose_cl = m_cl_db; end
    m_en_r2 = m_en_r1; m_en_r1 = rose_en;
    m_cl_r2 = m_cl_r1; m_cl_r1 = rose_cl;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      check("nums_o", nums_o, m_nums);
      check("count_o", 32'(count_o), 32'(m_count));
      check("start_clear_o", 32'(start_clear_o), 32'(m_sc));
      check("done_o", 32'(done_o), 32'(m_done));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic press(input logic en, input logic cl, input logic [3:0] v,
                       input int hold, input int rel);
    @(negedge clk_i);
    sw_i = v; enter_i = en; clear_i = cl;
    repeat (hold) @(negedge clk_i);
    enter_i = 0; clear_i = 0;
    repeat (rel) @(negedge clk_i);
  endtask

  // Enter press whose write edge is measured against the first sampling edge.
  task automatic press_timed(input logic [3:0] v);
    int start, got;
    logic [3:0] c0;
    @(negedge clk_i);
    c0 = count_o; sw_i = v; enter_i = 1; start = cyc; got = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (got < 0 && count_o != c0) got = cyc;
    end
    enter_i = 0;
    check("write_latency", 32'(got - start), 32'd8);
    repeat (10) @(negedge clk_i);
  endtask

  initial begin
    logic [3:0] fill_vals [8];
    fill_vals = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
    rst_ni = 0; sw_i = 0; enter_i = 0; clear_i = 0; valid_i = 0;
    idle(3);
    check("reset_nums", nums_o, 32'h0);
    check("reset_count", 32'(count_o), 32'd0);
    check("reset_start", 32'(start_clear_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    rst_ni = 1;
    idle(3);

    // Basic fill
    for (int i = 0; i < 8; i++) press_timed(fill_vals[i]);
    check("fill_nums", nums_o, 32'h6295_1413);
    check("fill_count", 32'(count_o), 32'd8);
    check("fill_start", 32'(start_clear_o), 32'd1);

    // Full handshake, with an enter attempted in DONE
    @(negedge clk_i); valid_i = 1;
    @(negedge clk_i);
    check("done_rise", 32'(done_o), 32'd1);
    press(1, 0, 4'hF, 10, 10);
    check("done_enter_nums", nums_o, 32'h6295_1413);
    check("done_enter_count", 32'(count_o), 32'd8);
    press(0, 1, 4'h0, 10, 10);
    check("release_start", 32'(start_clear_o), 32'd0);
    check("release_done", 32'(done_o), 32'd0);
    check("release_nums_held", nums_o, 32'h6295_1413);
    @(negedge clk_i); valid_i = 0;
    @(negedge clk_i);
    check("collect_nums", nums_o, 32'h0);
    check("collect_count", 32'(count_o), 32'd0);
    press(1, 0, 4'h7, 10, 10);
    check("slot0_nums", nums_o, 32'h7);
    check("slot0_count", 32'(count_o), 32'd1);

    // Glitch rejection
    press(1, 0, 4'hC, 3, 12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); enter_i = 1;
      @(negedge clk_i);
      @(negedge clk_i); enter_i = 0;
      @(negedge clk_i);
    end
    idle(12);
    check("glitch_count", 32'(count_o), 32'd1);
    check("glitch_nums", nums_o, 32'h7);

    // Three entries then clear
    press(1, 0, 4'h2, 10, 10);
    press(1, 0, 4'h3, 10, 10);
    check("three_nums", nums_o, 32'h327);
    press(0, 1, 4'h0, 10, 10);
    check("clear_nums", nums_o, 32'h0);
    check("clear_count", 32'(count_o), 32'd0);

    // Enter and clear together: clear wins
    press(1, 0, 4'h5, 10, 10);
    press(1, 0, 4'h6, 10, 10);
    press(1, 1, 4'h8, 10, 10);
    check("both_nums", nums_o, 32'h0);
    check("both_count", 32'(count_o), 32'd0);

    // Long hold gives one write
    press(1, 0, 4'hA, 100, 10);
    check("hold_nums", nums_o, 32'hA);
    check("hold_count", 32'(count_o), 32'd1);
    for (int v = 1; v < 8; v++) press(1, 0, 4'(v), 10, 10);
    check("run_nums", nums_o, 32'h7654_321A);
    check("run_start", 32'(start_clear_o), 32'd1);

    // Buttons ignored in RUN
    press(1, 0, 4'hF, 10, 10);
    press(0, 1, 4'h0, 10, 10);
    check("run_ignore_nums", nums_o, 32'h7654_321A);
    check("run_ignore_count", 32'(count_o), 32'd8);
    check("run_ignore_start", 32'(start_clear_o), 32'd1);

    // Asynchronous reset between edges
    @(posedge clk_i);
    #2 rst_ni = 0;
    #1;
    check("async_nums", nums_o, 32'h0);
    check("async_count", 32'(count_o), 32'd0);
    check("async_start", 32'(start_clear_o), 32'd0);
    check("async_done", 32'(done_o), 32'd0);
    idle(2);
    rst_ni = 1;
    press(1, 0, 4'h9, 10, 10);
    check("after_reset_nums", nums_o, 32'h9);
    check("after_reset_count", 32'(count_o), 32'd1);

    // Randomised segments checked by the per-cycle compare
    for (int s = 0; s < 1500; s++) begin
      @(negedge clk_i);
      sw_i    = 4'($urandom);
      enter_i = 1'($urandom_range(0, 1));
      clear_i = ($urandom_range(0, 7) == 0);
      valid_i = 1'($urandom_range(0, 1));
      rst_ni  = ($urandom_range(0, 199) != 0);
      repeat ($urandom_range(0, 11)) @(negedge clk_i);
    end
    rst_ni = 1; enter_i = 0; clear_i = 0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nums_loader.md
# nums_loader

Front-end input stage of the sorting design. Collects eight 4-bit operands entered one at a time from board switches and a push button, then packs them into the 32-bit operand word that feeds the counting-sort core. Drives the core's start/clear handshake: start is held high until the core reports valid and the user presses clear. Both raw buttons are synchronised and debounced internally.

## Interface
Parameters:
- DB_CYCLES, default 500000: consecutive stable cycles required before a debounced button level changes. Must be ≥ 1.

Ports:
- clk_i  in  1  system clock; all state changes on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- sw_i  in  4  raw switch value of the operand to enter
- enter_i  in  1  raw "enter" push button, active high
- clear_i  in  1  raw "clear" push button, active high
- valid_i  in  1  sort-complete flag from the sorting core
- nums_o  out  32  packed operands; slot k occupies [4k+3:4k]; first entry goes to slot 0
- start_clear_o  out  1  start (high) / clear (low) to the sorting core
- count_o  out  4  operands entered so far, 0..8
- done_o  out  1  sorted result available for display

## Operation
- Input conditioning:
  - sw_i, enter_i and clear_i each pass through a 2-flop synchroniser.
  - Each synchronised button feeds its own debouncer. A counter of width $clog2(DB_CYCLES+1) increments while the synchronised level differs from the debounced level and resets to 0 when they match. The debounced level flips when DB_CYCLES consecutive differing cycles have been counted.
  - A registered rising-edge detector produces a one-cycle pulse (enter_p, clear_p). Falling edges produce nothing.
- FSM states: COLLECT (reset), RUN, DONE, RELEASE.
- COLLECT:
  - clear_p: nums_o←0, count_o←0.
  - enter_p without clear_p: write synchronised sw_i into slot count_o, then count_o←count_o+1.
  - On the write that makes count_o=8: go to RUN and set start_clear_o←1 on the same edge.
  - clear_p and enter_p together: clear wins; nothing is written.
- RUN:
  - start_clear_o=1; nums_o frozen.
  - enter_p and clear_p are ignored. The core cannot be aborted.
  - valid_i=1: go to DONE, done_o←1.
- DONE:
  - start_clear_o=1, done_o=1; enter_p is ignored.
  - clear_p: go to RELEASE, start_clear_o←0, done_o←0.
- RELEASE:
  - start_clear_o=0; all button pulses are ignored.
  - valid_i=0: go to COLLECT, nums_o←0, count_o←0.
- count_o never exceeds 8 and never wraps.
- Reset values (asynchronous, on rst_ni low): nums_o=0, start_clear_o=0, count_o=0, done_o=0, state=COLLECT. All synchroniser flops, debounce counters, debounced levels and edge registers are also 0.
- Reset may be asserted mid-operation in any state. Outputs go to reset values immediately, without waiting for a clock edge.

## Timing
- Button to action: enter_i held high continuously from the first edge that samples it → nums_o/count_o update on edge DB_CYCLES+4. The same latency applies to clear_i.
- A button level held for fewer than DB_CYCLES cycles after synchronisation produces no pulse.
- One press gives exactly one action, however long it is held. The next action needs a release that is itself stable for DB_CYCLES cycles.
- start_clear_o rises on the same edge as the 8th write. nums_o is stable for the whole interval while start_clear_o=1.
- done_o rises one edge after valid_i is sampled high in RUN.
- start_clear_o falls one edge after clear_p is seen in DONE. It stays low in RELEASE until valid_i is sampled low.
- All outputs are registered; none is combinational from any input.

## Test plan
All scenarios use DB_CYCLES=4.
- Basic fill: after reset, enter 3,1,4,1,5,9,2,6 (each press held 10 cycles, released 10 cycles) → nums_o=32'h6295_1413, count_o=8. start_clear_o rises on the 8th write edge; each write lands exactly 8 edges after its press is first sampled.
- Full handshake: from RUN, raise valid_i → done_o=1 one edge later. Press clear → start_clear_o=0, done_o=0. Drop valid_i → nums_o=0, count_o=0, state COLLECT. The next enter writes slot 0.
- Glitch rejection: in COLLECT, pulse enter_i high for 3 cycles, and separately bounce it 1/0 every 2 cycles for 20 cycles → count_o and nums_o unchanged.
- Clear/priority rules:
  - Three entries then clear → nums_o=0, count_o=0.
  - Enter and clear debounced on the same cycle → clear wins, nothing written.
  - Clear or enter in RUN before valid_i → ignored, start_clear_o stays 1.
  - Enter in DONE → ignored.
- Long hold: enter_i held 100 cycles with sw_i=4'hA → exactly one write of A, count_o increments by 1.
- Async reset mid-RUN: drive rst_ni low between clock edges → all outputs 0 before the next edge. After release, the FSM is in COLLECT with count_o=0.
